// File: rtl/fan_batch_sequencer_if.sv
// rtl/fan_batch_sequencer_if.sv - element, FAN lane and result signals of fan_batch_sequencer
interface fan_batch_sequencer_if #(
    parameter int N = 32,
    parameter int W = 8,
    parameter int V = 3,
    parameter int S = W + $clog2(N)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_operand;
    logic [V-1:0]         in_vec_id;
    logic                 in_last;

    logic [N*W-1:0]       fan_operands;
    logic [N*V-1:0]       fan_vec_ids;
    logic [(N-1)*S-1:0]   fan_id_sums;
    logic [N-2:0]         fan_id_valids;

    logic                 out_valid;
    logic                 out_ready;
    logic [S-1:0]         out_sum;
    logic [V-1:0]         out_vec_id;

    modport slave (
        input  in_valid, in_operand, in_vec_id, in_last,
        input  fan_id_sums, fan_id_valids, out_ready,
        output in_ready, fan_operands, fan_vec_ids,
        output out_valid, out_sum, out_vec_id
    );

    modport master (
        output in_valid, in_operand, in_vec_id, in_last,
        output fan_id_sums, fan_id_valids, out_ready,
        input  in_ready, fan_operands, fan_vec_ids,
        input  out_valid, out_sum, out_vec_id
    );
endinterface

// File: rtl/fan_batch_sequencer.sv
// rtl/fan_batch_sequencer.sv - packs elements into N FAN lanes and streams the per-id sums back out
// Optional performance counters are built when FAN_SEQ_PERF_EN is defined.
module fan_batch_sequencer #(
    parameter int N = 32,
    parameter int W = 8,
    parameter int V = 3,
    parameter int S = W + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fan_batch_sequencer_if.slave bus,
`ifdef FAN_SEQ_PERF_EN
    output logic [31:0]          perf_batches,
    output logic [31:0]          perf_results,
    output logic [31:0]          perf_stall,
`endif
    output logic                 busy
);
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {FILL, PAD, COMPUTE, DRAIN} state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [W-1:0]  lane_op_q [N];
    logic [V-1:0]  lane_id_q [N];
    logic [V-1:0]  last_id_q;
    logic [S-1:0]  res_sum_q [N-1];
    logic [N-2:0]  res_valid_q;
    logic [KW-1:0] cur_idx_q;
    logic          out_valid_q;
    logic [S-1:0]  out_sum_q;
    logic [V-1:0]  out_vec_id_q;

    logic          lane1_split;
    logic          in_fire;
    logic          out_fire;
    logic [N-2:0]  pick_pool;
    logic          out_valid_d;
    logic [KW-1:0] cur_idx_d;
    logic [S-1:0]  out_sum_d;
    logic [V-1:0]  out_vec_id_d;

    // Lanes 0 and 1 must share an id, so a differing second element is held back
    // while lane 1 is padded with a zero carrying lane 0's id.
    assign lane1_split = (state_q == FILL) && (k_q == KW'(1)) && bus.in_valid
                         && (bus.in_vec_id != lane_id_q[0]);
    assign bus.in_ready = (state_q == FILL) && !lane1_split;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid_q && bus.out_ready;
    assign busy         = !((state_q == FILL) && (k_q == '0));

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.out_vec_id = out_vec_id_q;

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign bus.fan_operands[g*W +: W] = lane_op_q[g];
        assign bus.fan_vec_ids[g*V +: V]  = lane_id_q[g];
    end

    // Next result to present: straight from the FAN while capturing, otherwise
    // from the captured set with the result now being consumed masked out.
    always_comb begin
        pick_pool = (state_q == COMPUTE) ? bus.fan_id_valids
                  : (res_valid_q & ~({{(N-2){1'b0}}, 1'b1} << cur_idx_q));
        out_valid_d = 1'b0;
        cur_idx_d   = '0;
        for (int i = N - 2; i >= 0; i--) begin
            if (pick_pool[i]) begin
                out_valid_d = 1'b1;
                cur_idx_d   = KW'(i);
            end
        end
        out_sum_d    = (state_q == COMPUTE) ? bus.fan_id_sums[cur_idx_d*S +: S]
                                            : res_sum_q[cur_idx_d];
        out_vec_id_d = lane_id_q[cur_idx_d + KW'(1)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            k_q       <= '0;
            last_id_q <= '0;
            for (int i = 0; i < N; i++) begin
                lane_op_q[i] <= '0;
                lane_id_q[i] <= '0;
            end
            for (int i = 0; i < N - 1; i++) begin
                res_sum_q[i] <= '0;
            end
            res_valid_q  <= '0;
            cur_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_vec_id_q <= '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (lane1_split) begin
                        lane_op_q[1] <= '0;
                        lane_id_q[1] <= lane_id_q[0];
                        k_q          <= KW'(2);
                    end else if (in_fire) begin
                        lane_op_q[k_q] <= bus.in_operand;
                        lane_id_q[k_q] <= bus.in_vec_id;
                        last_id_q      <= bus.in_vec_id;
                        if (k_q == KW'(N - 1)) begin
                            k_q     <= '0;
                            state_q <= COMPUTE;
                        end else begin
                            k_q <= k_q + KW'(1);
                            if (bus.in_last) begin
                                state_q <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    for (int i = 0; i < N; i++) begin
                        if (KW'(i) >= k_q) begin
                            lane_op_q[i] <= '0;
                            lane_id_q[i] <= last_id_q;
                        end
                    end
                    k_q     <= '0;
                    state_q <= COMPUTE;
                end
                COMPUTE: begin
                    for (int i = 0; i < N - 1; i++) begin
                        res_sum_q[i] <= bus.fan_id_sums[i*S +: S];
                    end
                    res_valid_q  <= bus.fan_id_valids;
                    out_valid_q  <= out_valid_d;
                    out_sum_q    <= out_sum_d;
                    out_vec_id_q <= out_vec_id_d;
                    cur_idx_q    <= cur_idx_d;
                    state_q      <= out_valid_d ? DRAIN : FILL;
                end
                DRAIN: begin
                    if (out_fire) begin
                        res_valid_q[cur_idx_q] <= 1'b0;
                        out_valid_q  <= out_valid_d;
                        out_sum_q    <= out_sum_d;
                        out_vec_id_q <= out_vec_id_d;
                        cur_idx_q    <= cur_idx_d;
                        if (!out_valid_d) begin
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef FAN_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_batches <= '0;
            perf_results <= '0;
            perf_stall   <= '0;
        end else begin
            if (state_q == COMPUTE) begin
                perf_batches <= perf_batches + 32'd1;
            end
            if (out_fire) begin
                perf_results <= perf_results + 32'd1;
            end
            if (out_valid_q && !bus.out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fan_batch_sequencer.sv
// tb/tb_fan_batch_sequencer.sv - self-checking bench for fan_batch_sequencer at N=4
module tb_fan_batch_sequencer;
    localparam int N = 4;
    localparam int W = 8;
    localparam int V = 3;
    localparam int S = W + $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef FAN_SEQ_PERF_EN
    logic [31:0] perf_batches, perf_results, perf_stall;
    longint p0;
`endif

    fan_batch_sequencer_if #(.N(N), .W(W), .V(V), .S(S)) bus ();

    fan_batch_sequencer #(.N(N), .W(W), .V(V), .S(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
`ifdef FAN_SEQ_PERF_EN
        .perf_batches (perf_batches),
        .perf_results (perf_results),
        .perf_stall   (perf_stall),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // External FAN: segmented running sum over contiguous equal-id lanes;
    // output i belongs to lane i+1 and is valid where that lane ends its run.
    int lop [N];
    int lid [N+1];
    int run;
    always_comb begin
        run = 0;
        for (int j = 0; j < N; j++) begin
            lop[j] = int'(bus.fan_operands[j*W +: W]);
            lid[j] = int'(bus.fan_vec_ids[j*V +: V]);
        end
        lid[N] = lid[N-1] + 1;
        bus.fan_id_sums   = '0;
        bus.fan_id_valids = '0;
        for (int j = 0; j < N; j++) begin
            if (j > 0 && lid[j] != lid[j-1]) run = 0;
            run = run + lop[j];
            if (j > 0) begin
                bus.fan_id_sums[(j-1)*S +: S] = S'(run);
                bus.fan_id_valids[j-1]        = (lid[j+1] != lid[j]);
            end
        end
    end

    // Expected results derived from the element stream alone.
    typedef struct { int sum; int id; } res_t;
    res_t exp_q[$];
    int   m_op[$];
    int   m_id[$];

    function automatic void model_add(input int op, input int id, input bit last);
        int   s;
        res_t r;
        if (m_op.size() == 1 && id != m_id[0]) begin
            m_op.push_back(0);
            m_id.push_back(m_id[0]);
        end
        m_op.push_back(op);
        m_id.push_back(id);
        if (last || m_op.size() == N) begin
            while (m_op.size() < N) begin
                m_op.push_back(0);
                m_id.push_back(id);
            end
            s = 0;
            for (int j = 0; j < N; j++) begin
                s = s + m_op[j];
                if (j == N - 1 || m_id[j+1] != m_id[j]) begin
                    r.sum = s % (1 << S);
                    r.id  = m_id[j];
                    exp_q.push_back(r);
                    s = 0;
                end
            end
            m_op.delete();
            m_id.delete();
        end
    endfunction

    // Compare process: result content, hold-while-stalled, no input acceptance while draining.
    int   n_res = 0;
    int   last_sum = 0;
    int   last_id = 0;
    bit   prev_v = 1'b0;
    bit   prev_r = 1'b0;
    int   prev_s = 0;
    int   prev_id = 0;
    res_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_sum", bus.out_sum, prev_s);
                check("hold_id", bus.out_vec_id, prev_id);
            end
            if (bus.out_valid) check("in_ready_drain", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum %0d id %0d expected none", bus.out_sum, bus.out_vec_id);
                end else begin
                    e = exp_q.pop_front();
                    check("res_sum", bus.out_sum, e.sum);
                    check("res_id", bus.out_vec_id, e.id);
                end
                n_res++;
                last_sum = int'(bus.out_sum);
                last_id  = int'(bus.out_vec_id);
            end
            prev_v  = bus.out_valid;
            prev_r  = bus.out_ready;
            prev_s  = int'(bus.out_sum);
            prev_id = int'(bus.out_vec_id);
        end
    end

    bit rnd_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int op, input int id, input bit last);
        int t;
        t = 0;
        bus.in_valid   = 1'b1;
        bus.in_operand = W'(op);
        bus.in_vec_id  = V'(id);
        bus.in_last    = last;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            tick();
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            model_add(op, id, last);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 400) begin
            tick();
            t++;
        end
        check({name, "_idle"}, busy, 0);
        rnd_ready     = 1'b0;
        bus.out_ready = 1'b1;
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    int base;
    int t0;
    int s6_op [12] = '{2, 3, 4, 5, 7, 1, 6, 255, 255, 255, 255, 1};
    int s6_id [12] = '{1, 1, 2, 2, 3, 4, 4, 6, 6, 6, 6, 7};
    bit s6_ls [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_operand = '0;
        bus.in_vec_id  = '0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fan_ops", bus.fan_operands, 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", bus.in_ready, 1);

        // One full same-id batch, last on lane N-1, held under backpressure.
        send(5, 1, 0); send(6, 1, 0); send(7, 1, 0); send(8, 1, 1);
        check("s1_model_n", exp_q.size(), 1);
        check("s1_model_sum", exp_q[0].sum, 26);
        check("s1_latency_c1", bus.out_valid, 0);
        tick();
        check("s1_latency_c2", bus.out_valid, 1);
        check("s1_sum", bus.out_sum, 26);
        check("s1_id", bus.out_vec_id, 1);
`ifdef FAN_SEQ_PERF_EN
        p0 = longint'(perf_stall);
`endif
        repeat (5) tick();
        check("s1_hold_sum", bus.out_sum, 26);
`ifdef FAN_SEQ_PERF_EN
        check("s1_perf_stall", perf_stall, p0 + 5);
        check("s1_perf_batches", perf_batches, 1);
        check("s1_perf_results0", perf_results, 0);
`endif
        bus.out_ready = 1'b1;
        wait_idle("s1");
        check("s1_count", n_res, 1);
`ifdef FAN_SEQ_PERF_EN
        check("s1_perf_results1", perf_results, 1);
`endif

        // Lane-1 rule with a PAD batch.
        send(3, 2, 0);
        check("s2_busy_partial", busy, 1);
        send(4, 5, 1);
        check("s2_model_n", exp_q.size(), 2);
        check("s2_model_r0", exp_q[0].sum * 8 + exp_q[0].id, 3 * 8 + 2);
        check("s2_model_r1", exp_q[1].sum * 8 + exp_q[1].id, 4 * 8 + 5);
        tick();
        check("s2_lane_ops", bus.fan_operands, 32'h0004_0003);
        check("s2_lane_ids", bus.fan_vec_ids, 12'b101_101_010_010);
        wait_idle("s2");

        // PAD with the id of the last real element.
        send(9, 1, 0); send(1, 1, 0); send(2, 3, 1);
        check("s3_model_r0", exp_q[0].sum * 8 + exp_q[0].id, 10 * 8 + 1);
        check("s3_model_r1", exp_q[1].sum * 8 + exp_q[1].id, 2 * 8 + 3);
        tick();
        check("s3_lane_ops", bus.fan_operands, 32'h0002_0109);
        check("s3_lane_ids", bus.fan_vec_ids, 12'b011_011_001_001);
        wait_idle("s3");

        // Group split across two batches stays two results.
        base = n_res;
        send(1, 4, 0); send(2, 4, 0); send(3, 4, 0); send(4, 4, 0); send(5, 4, 1);
        wait_idle("s4");
        check("s4_count", n_res - base, 2);
        check("s4_second_sum", last_sum, 5);
        check("s4_second_id", last_id, 4);

        // Mixed stream under random backpressure, including the largest sum.
        base = n_res;
        rnd_ready = 1'b1;
        for (int i = 0; i < 12; i++) send(s6_op[i], s6_id[i], s6_ls[i]);
        rnd_ready = 1'b1;
        wait_idle("s5");
        check("s5_count", n_res - base, 6);

        // Reset while draining discards results.
        bus.out_ready = 1'b0;
        send(1, 1, 0); send(2, 1, 0); send(3, 2, 1);
        t0 = 0;
        while (!bus.out_valid && t0 < 20) begin
            tick();
            t0++;
        end
        check("s6_reached_drain", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_async_valid", bus.out_valid, 0);
        exp_q.delete();
        m_op.delete();
        m_id.delete();
`ifdef FAN_SEQ_PERF_EN
        check("s6_perf_rst", perf_batches + perf_results + perf_stall, 0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        base = n_res;
        repeat (3) tick();
        check("s6_busy_after", busy, 0);
        check("s6_valid_after", bus.out_valid, 0);
        send(5, 3, 0); send(5, 3, 0); send(5, 3, 0); send(5, 3, 1);
        check("s6_model_sum", exp_q[0].sum, 20);
        wait_idle("s6");
        check("s6_count", n_res - base, 1);
        check("s6_sum", last_sum, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
